// File: rtl/proc_controller.sv
// Instruction register and T0..T3 timestep sequencer for the 10-bit processor.
// Control outputs are a combinational decode of (step, ir_q); T0 only strobes ir_load.
module proc_controller #(
  parameter int IR_W  = 10,
  parameter int OP_W  = 4,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             CLRb,
  input  logic [IR_W-1:0]  Data_in,
  output logic [IR_W-1:0]  ir_q,
  output logic [1:0]       step,
  output logic             ext_en,
  output logic             rd_en,
  output logic [SEL_W-1:0] rd_sel,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_sel,
  output logic             a_load,
  output logic             g_load,
  output logic             g_en,
  output logic [OP_W-1:0]  alu_op,
  output logic             ir_load,
  output logic             done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [OP_W-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOV  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OP_W-1:0] OP_INV  = 4'b0100;
  localparam logic [OP_W-1:0] OP_FLP  = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0110;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1000;

  step_e            step_q, step_d;
  logic [SEL_W-1:0] rx, ry;
  logic [OP_W-1:0]  op;

  assign rx   = ir_q[IR_W-1 -: SEL_W];
  assign ry   = ir_q[IR_W-1-SEL_W -: SEL_W];
  assign op   = ir_q[IR_W-1-2*SEL_W -: OP_W];
  assign step = step_q;

  always_comb begin
    ext_en  = 1'b0;
    rd_en   = 1'b0;
    rd_sel  = '0;
    wr_en   = 1'b0;
    wr_sel  = '0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    g_en    = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    // Gated by CLRb so the capture strobe is low for the whole reset window.
    ir_load = (step_q == T0) && CLRb;

    if (step_q != T0) begin
      alu_op = op;
      case (op)
        OP_LOAD: begin
          if (step_q == T1) begin
            ext_en = 1'b1;
            wr_en  = 1'b1;
            wr_sel = rx;
            done   = 1'b1;
          end
        end
        OP_MOV: begin
          if (step_q == T1) begin
            rd_en  = 1'b1;
            rd_sel = ry;
            wr_en  = 1'b1;
            wr_sel = rx;
            done   = 1'b1;
          end
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          case (step_q)
            T1: begin
              rd_en  = 1'b1;
              rd_sel = rx;
              a_load = 1'b1;
            end
            T2: begin
              rd_en  = 1'b1;
              rd_sel = ry;
              g_load = 1'b1;
            end
            default: begin
              g_en   = 1'b1;
              wr_en  = 1'b1;
              wr_sel = rx;
              done   = 1'b1;
            end
          endcase
        end
        OP_INV, OP_FLP: begin
          if (step_q == T1) begin
            rd_en  = 1'b1;
            rd_sel = ry;
            g_load = 1'b1;
          end else if (step_q == T2) begin
            g_en   = 1'b1;
            wr_en  = 1'b1;
            wr_sel = rx;
            done   = 1'b1;
          end
        end
        default: done = 1'b1;
      endcase
    end

    if (done || step_q == T3) step_d = T0;
    else                      step_d = step_e'(step_q + 2'd1);
  end

  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      if (ir_load) ir_q <= Data_in;
    end
  end

endmodule

// File: tb/tb_proc_controller.sv
// Directed-vector bench for proc_controller: steps each instruction class and checks decode per timestep.
module tb_proc_controller;

  logic       CLK = 1'b0;
  logic       CLRb;
  logic [9:0] Data_in;
  logic [9:0] ir_q;
  logic [1:0] step;
  logic       ext_en, rd_en, wr_en, a_load, g_load, g_en, ir_load, done;
  logic [1:0] rd_sel, wr_sel;
  logic [3:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  proc_controller dut (
    .CLK     (CLK),
    .CLRb    (CLRb),
    .Data_in (Data_in),
    .ir_q    (ir_q),
    .step    (step),
    .ext_en  (ext_en),
    .rd_en   (rd_en),
    .rd_sel  (rd_sel),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .a_load  (a_load),
    .g_load  (g_load),
    .g_en    (g_en),
    .alu_op  (alu_op),
    .ir_load (ir_load),
    .done    (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control word order: ext rd rd_sel wr wr_sel a_load g_load g_en alu_op ir_load done
  task automatic expect_ctl(input string tag, input logic [1:0] st,
                            input logic e, input logic r, input logic [1:0] rs,
                            input logic w, input logic [1:0] ws,
                            input logic a, input logic g, input logic ge,
                            input logic [3:0] op, input logic il, input logic dn);
    logic [15:0] act;
    act = {ext_en, rd_en, rd_sel, wr_en, wr_sel, a_load, g_load, g_en, alu_op, ir_load, done};
    check({tag, "_step"}, 32'(step), 32'(st));
    check({tag, "_ctl"}, 32'(act), 32'({e, r, rs, w, ws, a, g, ge, op, il, dn}));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLRb    = 1'b0;
    Data_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ir", 32'(ir_q), 32'h0);
    expect_ctl("rst", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 0,0);

    CLRb = 1'b1;
    #1;
    expect_ctl("rel", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);

    // LOAD R1
    Data_in = 10'b01_00_0000_00;
    tick;
    check("load_ir", 32'(ir_q), 32'h100);
    expect_ctl("load_t1", 2'd1, 1,0,2'd0, 1,2'd1, 0,0,0, 4'h0, 0,1);
    tick;
    expect_ctl("load_t0", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);

    // ADD R2,R3 with Data_in disturbed after capture
    Data_in = 10'b10_11_0010_00;
    tick;
    Data_in = 10'b01_01_1111_11;
    expect_ctl("add_t1", 2'd1, 0,1,2'd2, 0,2'd0, 1,0,0, 4'h2, 0,0);
    tick;
    Data_in = 10'b00_00_0001_01;
    check("add_ir_t2", 32'(ir_q), 32'h2C8);
    expect_ctl("add_t2", 2'd2, 0,1,2'd3, 0,2'd0, 0,1,0, 4'h2, 0,0);
    tick;
    check("add_ir_t3", 32'(ir_q), 32'h2C8);
    expect_ctl("add_t3", 2'd3, 0,0,2'd0, 1,2'd2, 0,0,1, 4'h2, 0,1);
    tick;
    expect_ctl("add_t0", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);

    // INV R0,R1
    Data_in = 10'b00_01_0100_00;
    tick;
    expect_ctl("inv_t1", 2'd1, 0,1,2'd1, 0,2'd0, 0,1,0, 4'h4, 0,0);
    tick;
    expect_ctl("inv_t2", 2'd2, 0,0,2'd0, 1,2'd0, 0,0,1, 4'h4, 0,1);
    tick;
    expect_ctl("inv_t0", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);

    // MOV R3,R0
    Data_in = 10'b11_00_0001_00;
    tick;
    expect_ctl("mov_t1", 2'd1, 0,1,2'd0, 1,2'd3, 0,0,0, 4'h1, 0,1);
    tick;
    check("mov_ret", 32'(step), 32'd0);

    // Reserved opcode 1111 behaves as a one-step NOP
    Data_in = 10'b01_10_1111_00;
    tick;
    expect_ctl("rsv_t1", 2'd1, 0,0,2'd0, 0,2'd0, 0,0,0, 4'hF, 0,1);
    tick;
    expect_ctl("rsv_t0", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);

    // SUB R1,R2 aborted by reset in T2
    Data_in = 10'b01_10_0011_00;
    tick;
    expect_ctl("sub_t1", 2'd1, 0,1,2'd1, 0,2'd0, 1,0,0, 4'h3, 0,0);
    tick;
    expect_ctl("sub_t2", 2'd2, 0,1,2'd2, 0,2'd0, 0,1,0, 4'h3, 0,0);
    #2;
    CLRb = 1'b0;
    #1;
    check("abort_ir", 32'(ir_q), 32'h0);
    expect_ctl("abort", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 0,0);
    tick;
    expect_ctl("abort_hold", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 0,0);
    CLRb = 1'b1;

    // XOR R3,R1 captured on the first edge after release
    Data_in = 10'b11_01_1000_00;
    #1;
    expect_ctl("post_t0", 2'd0, 0,0,2'd0, 0,2'd0, 0,0,0, 4'h0, 1,0);
    tick;
    check("post_ir", 32'(ir_q), 32'h360);
    expect_ctl("xor_t1", 2'd1, 0,1,2'd3, 0,2'd0, 1,0,0, 4'h8, 0,0);
    tick;
    expect_ctl("xor_t2", 2'd2, 0,1,2'd1, 0,2'd0, 0,1,0, 4'h8, 0,0);
    tick;
    expect_ctl("xor_t3", 2'd3, 0,0,2'd0, 1,2'd3, 0,0,1, 4'h8, 0,1);
    tick;
    check("xor_ret", 32'(step), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
